// File: rtl/ula_seq.sv
// ula_seq: registered, handshaked ALU with flags and iterative one-bit-per-cycle shifts.
// Define ULA_MUL_EN to add the iterative unsigned multiplier on opcode 01100.
module ula_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic             illegal
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_ADDINC = 5'b00001;
    localparam logic [4:0] OP_INCA   = 5'b00011;
    localparam logic [4:0] OP_SUBDEC = 5'b00100;
    localparam logic [4:0] OP_SUB    = 5'b00101;
    localparam logic [4:0] OP_DECA   = 5'b00110;
    localparam logic [4:0] OP_LSL    = 5'b01000;
    localparam logic [4:0] OP_ASR    = 5'b01001;
    localparam logic [4:0] OP_LSR    = 5'b01010;
`ifdef ULA_MUL_EN
    localparam logic [4:0] OP_MUL    = 5'b01100;
`endif

`ifdef ULA_MUL_EN
    typedef enum logic [1:0] {IDLE, SHIFT, DONE, MUL} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t state, state_n;

    logic             accept;
    logic             is_shift;
    logic             go_shift;
    logic [CW-1:0]    n_sat;
    logic [CW-1:0]    cnt;
    logic [4:0]       op_q;

    logic [WIDTH-1:0] shift_val;
    logic [WIDTH-1:0] sh_src;
    logic [WIDTH-1:0] sh_next;
    logic [4:0]       sh_op;
    logic             sh_out;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_ill;
    logic [WIDTH-1:0] y_op;
    logic [WIDTH:0]   sum;
    logic             cin;
    logic             arith;
    logic             subf;

    logic             load;
    logic [WIDTH-1:0] fin_res;
    logic             fin_c;
    logic             fin_v;
    logic             fin_ill;

`ifdef ULA_MUL_EN
    logic                 start_mul;
    logic [2*WIDTH-1:0]   mul_acc;
    logic [2*WIDTH-1:0]   mul_cand;
    logic [WIDTH-1:0]     mul_plier;
    logic [2*WIDTH-1:0]   mul_acc_n;
    logic [2*WIDTH-1:0]   mul_cand_n;
    logic [WIDTH-1:0]     mul_plier_n;
`endif

    assign accept   = in_valid & in_ready;
    assign is_shift = (opcode == OP_LSL) || (opcode == OP_ASR) || (opcode == OP_LSR);
    assign go_shift = is_shift && (n_sat > CW'(1));
`ifdef ULA_MUL_EN
    assign start_mul = accept && (opcode == OP_MUL);
`endif

    // Shift amounts beyond the datapath width behave exactly like a full-width shift.
    always_comb begin
        if (32'(shamt) >= 32'(WIDTH)) begin
            n_sat = CW'(WIDTH);
        end else begin
            n_sat = CW'(shamt);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
`ifdef ULA_MUL_EN
                    if (start_mul) begin
                        state_n = MUL;
                    end else
`endif
                    if (go_shift) begin
                        state_n = SHIFT;
                    end else begin
                        state_n = DONE;
                    end
                end else if ((state == DONE) && out_ready) begin
                    state_n = IDLE;
                end
            end
            SHIFT: begin
                if (cnt == CW'(1)) begin
                    state_n = DONE;
                end
            end
`ifdef ULA_MUL_EN
            MUL: begin
                if (cnt == CW'(1)) begin
                    state_n = DONE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        out_valid = (state == DONE);
    end

    // The accept edge already performs the first shift step, so a shift of n bits takes n cycles.
    always_comb begin
        sh_src  = (state == SHIFT) ? shift_val : a;
        sh_op   = (state == SHIFT) ? op_q : opcode;
        sh_next = sh_src;
        sh_out  = 1'b0;
        case (sh_op)
            OP_LSL: begin
                sh_next = {sh_src[WIDTH-2:0], 1'b0};
                sh_out  = sh_src[WIDTH-1];
            end
            OP_ASR: begin
                sh_next = {sh_src[WIDTH-1], sh_src[WIDTH-1:1]};
                sh_out  = sh_src[0];
            end
            OP_LSR: begin
                sh_next = {1'b0, sh_src[WIDTH-1:1]};
                sh_out  = sh_src[0];
            end
            default: begin
                sh_next = sh_src;
                sh_out  = 1'b0;
            end
        endcase
    end

    // Subtraction is a + ~b + cin, so the unsigned borrow is the inverted carry-out.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        arith   = 1'b0;
        subf    = 1'b0;
        y_op    = b;
        cin     = 1'b0;
        case (opcode)
            OP_ADD:    arith = 1'b1;
            OP_ADDINC: begin arith = 1'b1; cin = 1'b1; end
            OP_INCA:   begin arith = 1'b1; y_op = '0; cin = 1'b1; end
            OP_SUBDEC: begin arith = 1'b1; subf = 1'b1; y_op = ~b; end
            OP_SUB:    begin arith = 1'b1; subf = 1'b1; y_op = ~b; cin = 1'b1; end
            OP_DECA:   begin arith = 1'b1; subf = 1'b1; y_op = '1; end
            OP_LSL, OP_ASR, OP_LSR: alu_res = a;
`ifdef ULA_MUL_EN
            OP_MUL:    alu_res = '0;
`endif
            5'b10000:  alu_res = '0;
            5'b10001:  alu_res = a & b;
            5'b10010:  alu_res = ~a & b;
            5'b10011:  alu_res = b;
            5'b10100:  alu_res = a & ~b;
            5'b10101:  alu_res = a;
            5'b10110:  alu_res = a ^ b;
            5'b10111:  alu_res = a | b;
            5'b11000:  alu_res = ~a & ~b;
            5'b11001:  alu_res = ~(a ^ b);
            5'b11010:  alu_res = ~a;
            5'b11011:  alu_res = ~a | b;
            5'b11100:  alu_res = ~b;
            5'b11101:  alu_res = a | ~b;
            5'b11110:  alu_res = ~a | ~b;
            5'b11111:  alu_res = '1;
            default:   alu_ill = 1'b1;
        endcase
        sum = {1'b0, a} + {1'b0, y_op} + {{WIDTH{1'b0}}, cin};
        if (arith) begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH] ^ subf;
            alu_v   = (a[WIDTH-1] == y_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end
    end

`ifdef ULA_MUL_EN
    // Shift-add multiplier: one multiplier bit per cycle, the first one on the accept edge.
    always_comb begin
        logic [2*WIDTH-1:0] acc_src;
        logic [2*WIDTH-1:0] cand_src;
        logic [WIDTH-1:0]   plier_src;
        if (state == MUL) begin
            acc_src   = mul_acc;
            cand_src  = mul_cand;
            plier_src = mul_plier;
        end else begin
            acc_src   = '0;
            cand_src  = {{WIDTH{1'b0}}, a};
            plier_src = b;
        end
        mul_acc_n   = acc_src + (plier_src[0] ? cand_src : '0);
        mul_cand_n  = cand_src << 1;
        mul_plier_n = plier_src >> 1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_acc   <= '0;
            mul_cand  <= '0;
            mul_plier <= '0;
        end else if (start_mul || (state == MUL)) begin
            mul_acc   <= mul_acc_n;
            mul_cand  <= mul_cand_n;
            mul_plier <= mul_plier_n;
        end
    end
`endif

    always_comb begin
        load    = 1'b0;
        fin_res = alu_res;
        fin_c   = alu_c;
        fin_v   = alu_v;
        fin_ill = alu_ill;
        if (state == SHIFT) begin
            fin_res = sh_next;
            fin_c   = sh_out;
            fin_v   = 1'b0;
            fin_ill = 1'b0;
            load    = (cnt == CW'(1));
        end
`ifdef ULA_MUL_EN
        else if (state == MUL) begin
            fin_res = mul_acc_n[WIDTH-1:0];
            fin_c   = |mul_acc_n[2*WIDTH-1:WIDTH];
            fin_v   = 1'b0;
            fin_ill = 1'b0;
            load    = (cnt == CW'(1));
        end
`endif
        else if (accept) begin
`ifdef ULA_MUL_EN
            if (start_mul) begin
                load = 1'b0;
            end else
`endif
            if (is_shift && (n_sat != '0)) begin
                fin_res = sh_next;
                fin_c   = sh_out;
                fin_v   = 1'b0;
                fin_ill = 1'b0;
                load    = (n_sat == CW'(1));
            end else begin
                load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= '0;
            shift_val <= '0;
            cnt       <= '0;
            result    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            negative  <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            if (accept) begin
                op_q      <= opcode;
                shift_val <= sh_next;
`ifdef ULA_MUL_EN
                cnt       <= start_mul ? CW'(WIDTH - 1) : (n_sat - CW'(1));
`else
                cnt       <= n_sat - CW'(1);
`endif
            end else if (state == SHIFT) begin
                shift_val <= sh_next;
                cnt       <= cnt - CW'(1);
            end
`ifdef ULA_MUL_EN
            else if (state == MUL) begin
                cnt <= cnt - CW'(1);
            end
`endif
            if (load) begin
                result   <= fin_res;
                zero     <= (fin_res == '0);
                carry    <= fin_c;
                overflow <= fin_v;
                negative <= fin_res[WIDTH-1];
                illegal  <= fin_ill;
            end
        end
    end

endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
- Parametrised, handshaked, registered successor to the combinational ALU.
- Keeps the 5-bit opcode map and generalises the datapath width (WIDTH).
- Adds registered flags (zero, carry, overflow, negative) and an illegal-opcode indication.
- Adds multi-bit iterative shifts that execute one bit per cycle.
- Sits between the register-file read stage and the writeback stage of the processor datapath.

Parameters:
- WIDTH, 32: operand and result width in bits (minimum 8).
- SHW, 5: shift-amount width; must satisfy 2**SHW >= WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands/opcode valid.
- in_ready  output  1  block can accept an operation.
- opcode  input  5  operation select.
- a  input  WIDTH  operand A, signed.
- b  input  WIDTH  operand B, signed.
- shamt  input  SHW  shift amount, used by shift opcodes only.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  operation result.
- zero  output  1  result == 0.
- carry  output  1  unsigned carry-out (add family); borrow (sub family); last bit shifted out (shifts); 0 otherwise.
- overflow  output  1  signed overflow (add/sub family only); 0 otherwise.
- negative  output  1  result[WIDTH-1].
- illegal  output  1  opcode not in the map.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - out_valid=0, result=0, all flags=0, illegal=0.
  - FSM to IDLE; in_ready=1 after reset deasserts.
  - Any in-flight operation is discarded; no partial result is ever presented.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept occurs when in_valid & in_ready. On accept, opcode/a/b/shamt are captured into internal registers.
- Accept of a non-shift opcode:
  - Result and flags are computed from the captured operands and registered; next state is DONE.
  - Latency 1: out_valid rises on the cycle after accept.
- Accept of a shift opcode (01000 lsl, 01001 asr, 01010 lsr):
  - shamt==0: behaves as a non-shift op; result=a, carry=0.
  - shamt>0: state goes to SHIFT; the internal value shifts by 1 bit per cycle and a counter decrements.
  - When the counter reaches 0, the result is registered and state goes to DONE. Latency = shamt cycles.
  - shamt >= WIDTH is saturated to WIDTH. Result is 0 for lsl/lsr and sign-fill for asr.
- DONE:
  - out_valid=1; result and flags are held stable until out_ready.
  - out_ready & in_valid in the same cycle: the new op is accepted back-to-back (no bubble); out_valid stays 1 only if the new op's latency is 1.
  - out_ready without in_valid: returns to IDLE and out_valid drops.
- Opcode map (all arithmetic wraps modulo 2**WIDTH):
  - 00000 add a+b
  - 00001 addinc a+b+1
  - 00011 inca a+1
  - 00100 subdec a-b-1
  - 00101 sub a-b
  - 00110 deca a-1
  - 10000 zeros 0
  - 10001 and
  - 10010 ~a&b
  - 10011 passb
  - 10100 a&~b
  - 10101 passa
  - 10110 xor
  - 10111 or
  - 11000 ~a&~b
  - 11001 xnor
  - 11010 ~a
  - 11011 ~a|b
  - 11100 ~b
  - 11101 a|~b
  - 11110 ~a|~b
  - 11111 ones: all bits 1
- Arithmetic rules:
  - Computed at WIDTH+1 bits; carry = bit WIDTH.
  - Sub family: carry=1 when a borrow occurs (unsigned a < b + dec).
  - overflow = operands' effective signs equal and result sign differs.
- Illegal opcodes (00010, 00111, 01011-01111): result=0, zero=1, illegal=1, latency 1; no other side effect.
- Flags always describe the presented result.

Optional Feature:
- ULA_MUL_EN defined: opcode 01100 is an unsigned multiply, low WIDTH bits of a*b.
  - Iterative shift-add in an added MUL state; latency WIDTH cycles.
  - carry=1 if any upper product bit is nonzero; overflow=0.
- ULA_MUL_EN undefined: 01100 is illegal as defined above and no multiplier logic exists.

Test Plan:
- Reset mid-SHIFT (lsl, shamt=20, reset at cycle 5) -> out_valid=0, result=0, in_ready=1 after release, no result emitted.
- add a=32'h7FFFFFFF b=1 -> after 1 cycle result=32'h80000000, overflow=1, negative=1, carry=0, zero=0.
- addinc a=32'hFFFFFFFF b=0 -> result=0, zero=1, carry=1, overflow=0.
- sub a=3 b=5 -> result=32'hFFFFFFFE, carry(borrow)=1, negative=1; ones -> 32'hFFFFFFFF.
- asr a=32'h80000010 shamt=4 -> out_valid after 4 cycles, result=32'hF8000001, carry=0; shamt=31 on lsl a=1 -> result=32'h80000000 after 31 cycles.
- Back-to-back: hold out_ready=0 for 3 cycles in DONE (result stable, in_ready=0), then out_ready=1 with in_valid (xor) -> new result next cycle with no bubble; opcode 00010 -> illegal=1, result=0.
